imem_loader: RTL and testbench

Boot-time writer for the 16-bit MIPS instruction RAM. It accepts a framed byte stream on a valid/ready interface, typically from a UART receiver. It assembles 16-bit instruction words and writes them sequentially into the instruction RAM write port, holding the processor in reset until a complete frame has loaded with a correct checksum. It sits between the serial receiver and the writable instruction memory. Its `cpu_hold` output drives the processor's `reset` input.

---
 rtl/mips16_pkg.sv | 19 +
 rtl/imem_loader_if.sv | 29 ++
 rtl/imem_loader.sv | 100 ++++++++++
 tb/tb_imem_loader.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips16_pkg.sv
// Shared definitions for the 16-bit MIPS boot path: loader state encoding,
// frame sync marker and instruction word width.
package mips16_pkg;

   localparam int INSN_W = 16;
   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   typedef enum logic [2:0] {
      IDLE,
      LEN,
      D_HI,
      D_LO,
      WRITE,
      CHK,
      DONE,
      ERR
   } load_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input, instruction RAM write port and boot status of the loader.
// master = the loader, slave = the byte source / RAM / CPU side.
interface imem_loader_if #(parameter int ADDR_W = 6);
   import mips16_pkg::*;

   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic              im_we;
   logic [ADDR_W-1:0] im_addr;
   logic [INSN_W-1:0] im_wd;
   logic              cpu_hold;
   logic              load_done;
   logic              load_err;
   logic [ADDR_W:0]   words_loaded;

   modport master (
      input  rx_data, rx_valid,
      output rx_ready, im_we, im_addr, im_wd,
             cpu_hold, load_done, load_err, words_loaded
   );

   modport slave (
      output rx_data, rx_valid,
      input  rx_ready, im_we, im_addr, im_wd,
             cpu_hold, load_done, load_err, words_loaded
   );

endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction RAM loader: parses SYNC/LEN/data/CHK frames, writes
// words sequentially and keeps the CPU in reset until a frame verifies.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for SYNC, other bytes dropped
// LEN   | next byte is the word count N
// D_HI  | next byte is the high byte of a word
// D_LO  | next byte is the low byte of a word
// WRITE | one-cycle RAM write, input stalled
// CHK   | next byte is the checksum
// DONE  | frame verified, CPU released; SYNC restarts
// ERR   | frame rejected, CPU held; SYNC restarts
module imem_loader #(
   parameter int ADDR_W = 6,
   parameter int DEPTH  = 64
) (
   input logic           clk,
   input logic           reset,
   imem_loader_if.master bus
);
   import mips16_pkg::*;

   load_state_t     state;
   logic [7:0]      len_q;
   logic [7:0]      chk_q;
   logic [7:0]      hi_q;
   logic [7:0]      lo_q;
   logic [ADDR_W:0] cnt_q;

   logic xfer;
   logic len_bad;
   logic last_word;

   assign xfer      = bus.rx_valid && (state != WRITE);
   assign len_bad   = (bus.rx_data == 8'd0) || (int'(bus.rx_data) > DEPTH);
   assign last_word = (int'(cnt_q) + 1 == int'(len_q));

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         len_q <= '0;
         chk_q <= '0;
         hi_q  <= '0;
         lo_q  <= '0;
         cnt_q <= '0;
      end else begin
         case (state)
            IDLE, DONE, ERR: begin
               if (xfer && bus.rx_data == SYNC_BYTE) state <= LEN;
            end
            LEN: begin
               if (xfer) begin
                  len_q <= bus.rx_data;
                  if (len_bad) begin
                     state <= ERR;
                  end else begin
                     chk_q <= bus.rx_data;
                     cnt_q <= '0;
                     state <= D_HI;
                  end
               end
            end
            D_HI: begin
               if (xfer) begin
                  hi_q  <= bus.rx_data;
                  chk_q <= chk_q ^ bus.rx_data;
                  state <= D_LO;
               end
            end
            D_LO: begin
               if (xfer) begin
                  lo_q  <= bus.rx_data;
                  chk_q <= chk_q ^ bus.rx_data;
                  state <= WRITE;
               end
            end
            WRITE: begin
               cnt_q <= cnt_q + 1'b1;
               state <= last_word ? CHK : D_HI;
            end
            CHK: begin
               if (xfer) state <= (bus.rx_data == chk_q) ? DONE : ERR;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // A reset landing on a WRITE cycle must not leave a stray word in the RAM.
   assign bus.im_we        = (state == WRITE) && !reset;
   assign bus.rx_ready     = (state != WRITE);
   assign bus.im_addr      = cnt_q[ADDR_W-1:0];
   assign bus.im_wd        = {hi_q, lo_q};
   assign bus.cpu_hold     = (state != DONE);
   assign bus.load_done    = (state == DONE);
   assign bus.load_err     = (state == ERR);
   assign bus.words_loaded = cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: frames are built from the framing rules,
// expected RAM writes are queued at issue time and popped by a write monitor.
module tb_imem_loader;
   import mips16_pkg::*;

   localparam int ADDR_W = 6;
   localparam int DEPTH  = 64;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [15:0]       wd;
   } wr_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   imem_loader_if #(.ADDR_W(ADDR_W)) bus ();
   imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

   int          n_cmp    = 0;
   int          n_err    = 0;
   int          edge_cnt = 0;
   int          exp_wl   = 0;
   wr_t         exp_q[$];
   wr_t         mon_e;
   logic [7:0]  tx_q[$];
   logic [15:0] wbuf[$];
   logic [15:0] model_ram [DEPTH];
   logic [15:0] dut_ram   [DEPTH];

   task automatic cmp(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Present one byte after an idle gap and hold it until the loader takes it.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int   tries;
      logic rdy;
      bus.rx_valid = 1'b0;
      for (int i = 0; i < gap; i++) begin
         @(posedge clk); #1;
         edge_cnt++;
      end
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      tries = 0;
      do begin
         @(negedge clk);
         rdy = bus.rx_ready;
         @(posedge clk); #1;
         edge_cnt++;
         tries++;
      end while (!rdy && tries < 8);
      if (!rdy) begin
         n_cmp++;
         n_err++;
         $display("FAIL accept_timeout: byte 0x%0h not accepted in %0d cycles", b, tries);
      end
      bus.rx_valid = 1'b0;
   endtask

   task automatic run_frame(input int n, input bit good, input int gmax);
      logic [7:0] c;
      bit         ok_len;
      ok_len = (n >= 1) && (n <= DEPTH);
      c      = 8'(n);
      tx_q   = {};
      if (ok_len) begin
         for (int i = 0; i < n; i++) begin
            tx_q.push_back(wbuf[i][15:8]);
            tx_q.push_back(wbuf[i][7:0]);
            c = c ^ wbuf[i][15:8] ^ wbuf[i][7:0];
            exp_q.push_back(wr_t'{addr: ADDR_W'(i), wd: wbuf[i]});
            model_ram[i] = wbuf[i];
         end
      end
      edge_cnt = 0;
      send_byte(SYNC_BYTE, $urandom_range(0, gmax));
      cmp("sync_hold", int'(bus.cpu_hold), 1);
      cmp("sync_done", int'(bus.load_done), 0);
      cmp("sync_err", int'(bus.load_err), 0);
      send_byte(8'(n), $urandom_range(0, gmax));
      if (!ok_len) begin
         cmp("badlen_err", int'(bus.load_err), 1);
         cmp("badlen_hold", int'(bus.cpu_hold), 1);
         cmp("badlen_done", int'(bus.load_done), 0);
         cmp("badlen_wl", int'(bus.words_loaded), exp_wl);
         return;
      end
      exp_wl = 0;
      cmp("len_wl", int'(bus.words_loaded), 0);
      foreach (tx_q[i]) send_byte(tx_q[i], $urandom_range(0, gmax));
      cmp("pre_chk_hold", int'(bus.cpu_hold), 1);
      send_byte(good ? c : (c ^ 8'h07), $urandom_range(0, gmax));
      exp_wl = n;
      cmp("writes_drained", exp_q.size(), 0);
      cmp("words_loaded", int'(bus.words_loaded), n);
      cmp("load_done", int'(bus.load_done), int'(good));
      cmp("load_err", int'(bus.load_err), int'(!good));
      cmp("cpu_hold", int'(bus.cpu_hold), int'(!good));
      if (gmax == 0) cmp("frame_cycles", edge_cnt, 3 * n + 3);
   endtask

   task automatic compare_ram(input string name);
      for (int i = 0; i < DEPTH; i++) cmp(name, int'(dut_ram[i]), int'(model_ram[i]));
   endtask

   always @(negedge clk) begin
      if (reset) begin
         cmp("we_in_reset", int'(bus.im_we), 0);
      end else begin
         cmp("ready_vs_write", int'(bus.rx_ready), int'(!bus.im_we));
         if (bus.im_we) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                        bus.im_addr, bus.im_wd);
            end else begin
               mon_e = exp_q.pop_front();
               cmp("wr_addr", int'(bus.im_addr), int'(mon_e.addr));
               cmp("wr_data", int'(bus.im_wd), int'(mon_e.wd));
            end
            dut_ram[bus.im_addr] = bus.im_wd;
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      for (int i = 0; i < DEPTH; i++) begin
         model_ram[i] = 16'h0;
         dut_ram[i]   = 16'h0;
      end
      repeat (3) @(posedge clk);
      #1;
      cmp("rst_hold", int'(bus.cpu_hold), 1);
      cmp("rst_ready", int'(bus.rx_ready), 1);
      cmp("rst_we", int'(bus.im_we), 0);
      cmp("rst_addr", int'(bus.im_addr), 0);
      cmp("rst_wd", int'(bus.im_wd), 0);
      cmp("rst_done", int'(bus.load_done), 0);
      cmp("rst_err", int'(bus.load_err), 0);
      cmp("rst_wl", int'(bus.words_loaded), 0);
      reset = 1'b0;

      // Garbage before SYNC is dropped without leaving IDLE.
      send_byte(8'h00, 0);
      send_byte(8'hFF, 0);
      send_byte(8'h12, 0);
      cmp("garbage_hold", int'(bus.cpu_hold), 1);
      cmp("garbage_done", int'(bus.load_done), 0);
      cmp("garbage_err", int'(bus.load_err), 0);

      wbuf = '{16'hE189, 16'hE107, 16'h09C0, 16'h4000};
      run_frame(4, 1'b1, 0);
      run_frame(4, 1'b0, 0);
      run_frame(4, 1'b1, 2);

      run_frame(0, 1'b1, 0);
      run_frame(65, 1'b1, 0);

      // SYNC-valued data inside a frame is payload.
      send_byte(8'h00, 0);
      send_byte(8'hFF, 0);
      send_byte(8'h12, 0);
      wbuf = '{16'hA5A5, 16'h1234, 16'h00A5};
      run_frame(3, 1'b1, 1);
      compare_ram("ram_a5");

      // Reset during the third word's write: two words land, the third does not.
      wbuf = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back(wr_t'{addr: ADDR_W'(i), wd: wbuf[i]});
         model_ram[i] = wbuf[i];
      end
      send_byte(SYNC_BYTE, 0);
      send_byte(8'h04, 0);
      for (int i = 0; i < 3; i++) begin
         send_byte(wbuf[i][15:8], 0);
         send_byte(wbuf[i][7:0], 0);
      end
      reset = 1'b1;
      @(posedge clk); #1;
      cmp("mid_rst_hold", int'(bus.cpu_hold), 1);
      cmp("mid_rst_wl", int'(bus.words_loaded), 0);
      cmp("mid_rst_done", int'(bus.load_done), 0);
      cmp("mid_rst_err", int'(bus.load_err), 0);
      cmp("mid_rst_ready", int'(bus.rx_ready), 1);
      cmp("mid_rst_addr", int'(bus.im_addr), 0);
      cmp("mid_rst_wd", int'(bus.im_wd), 0);
      cmp("mid_rst_drained", exp_q.size(), 0);
      reset  = 1'b0;
      exp_wl = 0;
      compare_ram("ram_partial");

      wbuf = '{16'hE189, 16'hE107, 16'h09C0, 16'h4000};
      run_frame(4, 1'b1, 0);
      compare_ram("ram_after_rst");

      // Same random image loaded three times under random source stalls.
      n    = $urandom_range(1, DEPTH);
      wbuf = {};
      for (int i = 0; i < n; i++) wbuf.push_back(16'($urandom));
      for (int r = 0; r < 3; r++) begin
         run_frame(n, 1'b1, 5);
         compare_ram("ram_random");
      end
      run_frame(DEPTH, 1'b1, 0);
      compare_ram("ram_full_depth");

      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
